// File: rtl/dmas_sign_mag_feeder.sv
// Buffers delay-aligned RF samples and replays each pixel's channels as an
// unbroken sign/magnitude burst, framed by a clear pulse and a flush gap.
module dmas_sign_mag_feeder #(
    parameter int unsigned CHANNELS   = 128,
    parameter int unsigned CH_BITS    = 8,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned PIXELS     = 1,
    parameter int unsigned PIX_BITS   = 1,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [15:0]                   s_data,
    output logic                          pix_clr,
    output logic                          out_valid,
    output logic [15:0]                   out_mag,
    output logic [1:0]                    out_sign,
    output logic                          out_first,
    output logic                          out_last,
    output logic [CH_BITS-1:0]            ch_idx,
    output logic [PIX_BITS-1:0]           pix_idx,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CH_BITS-1:0]  LAST_CH     = CH_BITS'(CHANNELS - 1);
    localparam logic [CH_BITS-1:0]  PRELAST_CH  = CH_BITS'(CHANNELS - 2);
    localparam logic [PIX_BITS-1:0] LAST_PIX    = PIX_BITS'(PIXELS - 1);
    localparam logic [GAP_W-1:0]    LAST_GAP    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    FULL_COUNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]    BURST_COUNT = CNT_W'(CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        BURST,
        GAP
    } state_t;

    state_t             state;
    logic [15:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic               push;
    logic               pop;
    logic [15:0]        rd_data;
    logic               rd_neg;
    logic [15:0]        rd_mag;

    assign s_ready = !rst && (fifo_count < FULL_COUNT);
    assign push    = s_valid && s_ready;
    // One read in ARM pre-loads channel 0; the burst reads the remaining ones.
    assign pop     = (state == ARM) || ((state == BURST) && (ch_idx != LAST_CH));

    // Sign/magnitude conversion at the read port; -32768 maps to 32768 unsaturated.
    assign rd_data = mem[rd_ptr];
    assign rd_neg  = rd_data[15];
    assign rd_mag  = rd_neg ? (~rd_data + 16'd1) : rd_data;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            gap_cnt    <= '0;
            pix_clr    <= 1'b0;
            out_valid  <= 1'b0;
            out_mag    <= 16'd0;
            out_sign   <= 2'b01;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
            ch_idx     <= '0;
            pix_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            pix_clr    <= 1'b0;
            frame_done <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                IDLE: begin
                    if (fifo_count >= BURST_COUNT) begin
                        state   <= ARM;
                        pix_clr <= 1'b1;
                    end
                end
                ARM: begin
                    state     <= BURST;
                    out_valid <= 1'b1;
                    out_first <= 1'b1;
                    out_last  <= 1'b0;
                    ch_idx    <= '0;
                    out_mag   <= rd_mag;
                    out_sign  <= rd_neg ? 2'b11 : 2'b01;
                end
                BURST: begin
                    if (ch_idx == LAST_CH) begin
                        state     <= GAP;
                        gap_cnt   <= '0;
                        out_valid <= 1'b0;
                        out_first <= 1'b0;
                        out_last  <= 1'b0;
                        if (pix_idx == LAST_PIX) begin
                            pix_idx    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            pix_idx <= pix_idx + 1'b1;
                        end
                    end else begin
                        ch_idx    <= ch_idx + 1'b1;
                        out_first <= 1'b0;
                        out_last  <= (ch_idx == PRELAST_CH);
                        out_mag   <= rd_mag;
                        out_sign  <= rd_neg ? 2'b11 : 2'b01;
                    end
                end
                GAP: begin
                    if (gap_cnt == LAST_GAP) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmas_sign_mag_feeder.sv
// Randomized scoreboard bench for dmas_sign_mag_feeder: a sample queue plus
// burst/gap timing rules predict every output cycle.
module tb_dmas_sign_mag_feeder;

    localparam int CH    = 128;
    localparam int DEPTH = 256;
    localparam int PIX   = 4;
    localparam int GAP   = 8;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        pix_clr;
    logic        out_valid;
    logic [15:0] out_mag;
    logic [1:0]  out_sign;
    logic        out_first;
    logic        out_last;
    logic [7:0]  ch_idx;
    logic [1:0]  pix_idx;
    logic        frame_done;
    logic [8:0]  fifo_count;

    dmas_sign_mag_feeder #(
        .CHANNELS(CH), .CH_BITS(8), .FIFO_DEPTH(DEPTH),
        .PIXELS(PIX), .PIX_BITS(2), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .pix_clr(pix_clr), .out_valid(out_valid),
        .out_mag(out_mag), .out_sign(out_sign), .out_first(out_first),
        .out_last(out_last), .ch_idx(ch_idx), .pix_idx(pix_idx),
        .frame_done(frame_done), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic signed [15:0] sq[$];
    int   pushed, popped, beat_k, cool, cnt, v, ch_e, pix_e;
    logic prev_clr, prev_valid, prev_last, prev_fend, exp_clr, after_rst, idle, saw_full;
    logic signed [15:0] d;

    initial begin
        pushed = 0; popped = 0; beat_k = 0; cool = 0;
        prev_clr = 0; prev_valid = 0; prev_last = 0; prev_fend = 0;
        exp_clr = 0; after_rst = 0; saw_full = 0;
    end

    // Monitor: every cycle predicts valid/clear/frame timing, beat content and occupancy.
    always @(negedge clk) begin
        if (rst) begin
            chk("s_ready_in_reset", 32'(s_ready), 32'd0);
            sq.delete();
            pushed = 0; popped = 0; beat_k = 0; cool = 0;
            prev_clr = 0; prev_valid = 0; prev_last = 0; prev_fend = 0;
            exp_clr = 0; after_rst = 1;
        end else begin
            if (after_rst) begin
                chk("rst_out_mag", 32'(out_mag), 32'd0);
                chk("rst_out_sign", 32'(out_sign), 32'd1);
                chk("rst_ch_idx", 32'(ch_idx), 32'd0);
                chk("rst_pix_idx", 32'(pix_idx), 32'd0);
                chk("rst_flags", {28'd0, out_first, out_last, frame_done, pix_clr}, 32'd0);
                after_rst = 0;
            end
            chk("out_valid", 32'(out_valid), 32'(prev_clr || (prev_valid && !prev_last)));
            chk("pix_clr", 32'(pix_clr), 32'(exp_clr));
            chk("frame_done", 32'(frame_done), 32'(prev_fend));
            prev_fend = 0;
            if (out_valid) begin
                ch_e  = beat_k % CH;
                pix_e = (beat_k / CH) % PIX;
                if (sq.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL beat_without_sample: got beat ch %0d expected none at %0t", ch_idx, $time);
                end else begin
                    d = sq.pop_front();
                    v = int'(d);
                    chk("out_mag", 32'(out_mag), 32'((v < 0) ? -v : v));
                    chk("out_sign", 32'(out_sign), (v < 0) ? 32'd3 : 32'd1);
                end
                chk("ch_idx", 32'(ch_idx), 32'(ch_e));
                chk("pix_idx", 32'(pix_idx), 32'(pix_e));
                chk("out_first", 32'(out_first), 32'(ch_e == 0));
                chk("out_last", 32'(out_last), 32'(ch_e == CH - 1));
                prev_fend = (ch_e == CH - 1) && (pix_e == PIX - 1);
                popped++;
                beat_k++;
            end
            cnt = pushed - popped;
            chk("fifo_count", 32'(fifo_count), 32'(cnt));
            chk("s_ready", 32'(s_ready), 32'(cnt < DEPTH));
            if (cnt == DEPTH) saw_full = 1;
            // A clear follows any idle cycle that sees a full pixel buffered.
            idle = !pix_clr && !out_valid && (cool == 0);
            if (out_valid && out_last) cool = GAP;
            else if (cool > 0) cool--;
            exp_clr = idle && (cnt >= CH);
            prev_clr = pix_clr; prev_valid = out_valid; prev_last = out_last;
            if (s_valid && s_ready) begin
                sq.push_back(s_data);
                pushed++;
            end
        end
    end

    task automatic push(input logic [15:0] x);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = x;
        @(negedge clk);
        while (!s_ready) begin
            n++;
            if (n > 5000) begin
                $display("FAIL push_timeout: got s_ready 0 expected 1 within 5000 cycles");
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (sq.size() == 0 && !out_valid && !pix_clr) break;
            n++;
            if (n > 20000) begin
                $display("FAIL drain_timeout: got %0d queued expected 0", sq.size());
                $fatal(1);
            end
        end
        idle_cycles(GAP + 4);
    endtask

    task automatic push_random(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 0) idle_cycles(1);
            end
            push(16'($urandom));
        end
        s_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] corner [5];
        corner[0] = 16'hFFFB; corner[1] = 16'h0000; corner[2] = 16'h0007;
        corner[3] = 16'h8000; corner[4] = 16'h7FFF;
        rst = 1'b1; s_valid = 1'b0; s_data = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Ascending ramp, one full pixel.
        for (int i = 0; i < CH; i++) push(16'(i));
        s_valid = 1'b0;
        drain();

        // Sign/magnitude corner values followed by fillers.
        for (int i = 0; i < 5; i++) push(corner[i]);
        push_random(CH - 5, 1'b0);
        drain();

        // One short of a pixel must not start a burst.
        push_random(CH - 1, 1'b0);
        idle_cycles(30);
        push(16'($urandom));
        drain();

        // Continuous streaming long enough to hit full backpressure.
        saw_full = 0;
        push_random(30 * CH, 1'b0);
        drain();
        chk("fifo_reached_full", 32'(saw_full), 32'd1);

        // Reset in the middle of a burst, then a clean pixel.
        push_random(CH, 1'b1);
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (out_valid && ch_idx == 8'd59) break;
            n++;
            if (n > 5000) begin
                $display("FAIL burst_wait_timeout: got no beat 59 expected one");
                $fatal(1);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        push_random(CH, 1'b0);
        drain();

        // Randomly throttled input across ten pixels.
        push_random(10 * CH, 1'b1);
        drain();
        chk("final_queue_empty", 32'(sq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
